run_meter: RTL and testbench

Downstream consumer of the two-consecutive-high detector: takes its qualified level output and measures every high run. For each completed run it reports the run length on a one-deep valid/ready output register and keeps a saturating run count and a sticky overflow flag. Sits between the detector and the status/logging logic, so that logic never has to sample the raw level every cycle.

---
 rtl/run_meter.sv | 112 +++++++++++
 tb/tb_run_meter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_meter.sv
// run_meter: measures every high run of a qualified level input.
// Each completed run is reported on a one-deep valid/ready output register
// together with a saturation flag. A saturating count of completed runs and
// a sticky overflow flag (run dropped because the output was still full)
// are kept alongside.
module run_meter #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             level_in,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [LEN_W-1:0] run_len,
    output logic             run_sat,
    output logic [CNT_W-1:0] event_count,
    output logic             overflow
);

    localparam logic             ST_IDLE = 1'b0;
    localparam logic             ST_RUN  = 1'b1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             state_reg;
    logic [LEN_W-1:0] len_reg;
    logic             sat_reg;

    logic             run_done;
    logic             out_accept;
    logic             out_free;
    logic [LEN_W-1:0] len_inc;

    // Decode run completion and output-register availability for this edge.
    always_comb begin
        run_done   = (state_reg == ST_RUN) && !level_in;
        out_accept = run_valid && run_ready;
        out_free   = !run_valid || run_ready;
        len_inc    = (len_reg == LEN_MAX) ? LEN_MAX : len_reg + 1'b1;
    end

    // Measurement FSM: counts samples of a high level, never stalls on output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            sat_reg   <= 1'b0;
        end else if (clear) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (level_in) begin
                        state_reg <= ST_RUN;
                        len_reg   <= {{(LEN_W-1){1'b0}}, 1'b1};
                        // A one-bit counter is already at its maximum after one sample.
                        sat_reg   <= (LEN_W == 1);
                    end
                end
                default: begin
                    if (level_in) begin
                        len_reg <= len_inc;
                        if (len_inc == LEN_MAX) begin
                            sat_reg <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output register, run counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_valid   <= 1'b0;
            run_len     <= '0;
            run_sat     <= 1'b0;
            event_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            run_valid   <= 1'b0;
            run_len     <= '0;
            run_sat     <= 1'b0;
            event_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (run_done) begin
                if (event_count != CNT_MAX) begin
                    event_count <= event_count + 1'b1;
                end
                if (out_free) begin
                    // Either empty or being drained at this edge: take the new run.
                    run_valid <= 1'b1;
                    run_len   <= len_reg;
                    run_sat   <= sat_reg;
                end else begin
                    // Held result wins; the new one is lost and flagged.
                    overflow  <= 1'b1;
                end
            end else if (out_accept) begin
                run_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_run_meter.sv
// Directed testbench for run_meter. Three instances share the stimulus:
// default widths, a 4-bit length counter, and a 2-bit run counter.
`timescale 1ns/1ps
module tb_run_meter;

    logic clk;
    logic rst_n;
    logic clear;
    logic level_in;
    logic run_ready;

    logic       v8;
    logic [7:0] len8;
    logic       sat8;
    logic [7:0] cnt8;
    logic       ovf8;

    logic       v4;
    logic [3:0] len4;
    logic       sat4;
    logic [7:0] cnt4;
    logic       ovf4;

    logic       vc;
    logic [7:0] lenc;
    logic       satc;
    logic [1:0] cntc;
    logic       ovfc;

    int vectors;
    int miscompares;

    run_meter #(.LEN_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .level_in(level_in),
        .run_valid(v8), .run_ready(run_ready), .run_len(len8), .run_sat(sat8),
        .event_count(cnt8), .overflow(ovf8)
    );

    run_meter #(.LEN_W(4), .CNT_W(8)) dut_len4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .level_in(level_in),
        .run_valid(v4), .run_ready(run_ready), .run_len(len4), .run_sat(sat4),
        .event_count(cnt4), .overflow(ovf4)
    );

    run_meter #(.LEN_W(8), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .level_in(level_in),
        .run_valid(vc), .run_ready(run_ready), .run_len(lenc), .run_sat(satc),
        .event_count(cntc), .overflow(ovfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are observed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; level_in = 1'b0; run_ready = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
        vectors++;
        if ({v8, len8, sat8, cnt8, ovf8} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0b len=%0d sat=%0b cnt=%0d ovf=%0b, want all 0",
                     v8, len8, sat8, cnt8, ovf8);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_run();
        run_ready = 1'b1;
        level_in = 1'b1; steps(3);
        vectors++;
        if (v8 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_no_early_valid: got %0b want 0", v8);
        end
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8, sat8, cnt8} !== {1'b1, 8'd3, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL basic_report: got v=%0b len=%0d sat=%0b cnt=%0d, want v=1 len=3 sat=0 cnt=1",
                     v8, len8, sat8, cnt8);
        end
        step();
        vectors++;
        if (v8 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drained: got v=%0b want 0", v8);
        end
        $display("test_basic_run done");
    endtask

    task automatic test_saturation();
        logic early;
        do_clear();
        run_ready = 1'b1;
        early = 1'b0;
        level_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (v4) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_no_early_report: got early valid=%0b want 0", early);
        end
        level_in = 1'b0; step();
        vectors++;
        if ({v4, len4, sat4, cnt4} !== {1'b1, 4'd15, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL sat_len4_report: got v=%0b len=%0d sat=%0b cnt=%0d, want v=1 len=15 sat=1 cnt=1",
                     v4, len4, sat4, cnt4);
        end
        vectors++;
        if ({v8, len8, sat8} !== {1'b1, 8'd20, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_len8_unsaturated: got v=%0b len=%0d sat=%0b, want v=1 len=20 sat=0",
                     v8, len8, sat8);
        end
        step();
        vectors++;
        if (v4 !== 1'b0 || cnt4 !== 8'd1) begin
            miscompares++;
            $display("FAIL sat_single_report: got v=%0b cnt=%0d, want v=0 cnt=1", v4, cnt4);
        end
        $display("test_saturation done");
    endtask

    task automatic test_overflow();
        do_clear();
        run_ready = 1'b0;
        level_in = 1'b1; steps(2);
        level_in = 1'b0; step();
        level_in = 1'b1; steps(5);
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8, cnt8, ovf8} !== {1'b1, 8'd2, 8'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_held: got v=%0b len=%0d cnt=%0d ovf=%0b, want v=1 len=2 cnt=2 ovf=1",
                     v8, len8, cnt8, ovf8);
        end
        run_ready = 1'b1; step();
        vectors++;
        if ({v8, ovf8} !== 2'b01) begin
            miscompares++;
            $display("FAIL ovf_drain: got v=%0b ovf=%0b, want v=0 ovf=1", v8, ovf8);
        end
        steps(2);
        vectors++;
        if ({v8, ovf8} !== 2'b01) begin
            miscompares++;
            $display("FAIL ovf_sticky: got v=%0b ovf=%0b, want v=0 ovf=1", v8, ovf8);
        end
        $display("test_overflow done");
    endtask

    task automatic test_simultaneous();
        do_clear();
        run_ready = 1'b0;
        level_in = 1'b1; steps(4);
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8} !== {1'b1, 8'd4}) begin
            miscompares++;
            $display("FAIL simul_first: got v=%0b len=%0d, want v=1 len=4", v8, len8);
        end
        level_in = 1'b1; step();
        level_in = 1'b0; run_ready = 1'b1; step();
        vectors++;
        if ({v8, len8, ovf8, cnt8} !== {1'b1, 8'd1, 1'b0, 8'd2}) begin
            miscompares++;
            $display("FAIL simul_replace: got v=%0b len=%0d ovf=%0b cnt=%0d, want v=1 len=1 ovf=0 cnt=2",
                     v8, len8, ovf8, cnt8);
        end
        step();
        vectors++;
        if (v8 !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_drain: got v=%0b want 0", v8);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_back_to_back();
        do_clear();
        run_ready = 1'b1;
        level_in = 1'b1; step();
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8, cnt8} !== {1'b1, 8'd1, 8'd1}) begin
            miscompares++;
            $display("FAIL b2b_first: got v=%0b len=%0d cnt=%0d, want v=1 len=1 cnt=1", v8, len8, cnt8);
        end
        level_in = 1'b1; step();
        vectors++;
        if (v8 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got v=%0b want 0", v8);
        end
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8, cnt8, ovf8} !== {1'b1, 8'd1, 8'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%0b len=%0d cnt=%0d ovf=%0b, want v=1 len=1 cnt=2 ovf=0",
                     v8, len8, cnt8, ovf8);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        // Leave cnt8=2 from the previous test so the reset has something to zero.
        step();
        level_in = 1'b1; steps(6);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({v8, len8, sat8, cnt8, ovf8} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got v=%0b len=%0d sat=%0b cnt=%0d ovf=%0b, want all 0",
                     v8, len8, sat8, cnt8, ovf8);
        end
        #1 rst_n = 1'b1;
        steps(3);
        level_in = 1'b0; step();
        vectors++;
        if ({v8, len8, cnt8} !== {1'b1, 8'd3, 8'd1}) begin
            miscompares++;
            $display("FAIL async_reset_remeasure: got v=%0b len=%0d cnt=%0d, want v=1 len=3 cnt=1",
                     v8, len8, cnt8);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_count_sat_and_clear();
        do_clear();
        run_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            level_in = 1'b1; step();
            level_in = 1'b0; step();
        end
        vectors++;
        if (cntc !== 2'd3) begin
            miscompares++;
            $display("FAIL cnt2_saturate: got %0d want 3", cntc);
        end
        vectors++;
        if (cnt8 !== 8'd5) begin
            miscompares++;
            $display("FAIL cnt8_five: got %0d want 5", cnt8);
        end
        do_clear();
        vectors++;
        if ({vc, lenc, satc, cntc, ovfc} !== 13'd0) begin
            miscompares++;
            $display("FAIL clear_outputs: got v=%0b len=%0d sat=%0b cnt=%0d ovf=%0b, want all 0",
                     vc, lenc, satc, cntc, ovfc);
        end
        // Clear coinciding with a run completion suppresses the report.
        level_in = 1'b1; step();
        level_in = 1'b0; clear = 1'b1; step();
        clear = 1'b0;
        vectors++;
        if ({v8, cnt8} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_beats_completion: got v=%0b cnt=%0d, want v=0 cnt=0", v8, cnt8);
        end
        step();
        vectors++;
        if ({v8, cnt8} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL clear_no_late_report: got v=%0b cnt=%0d, want v=0 cnt=0", v8, cnt8);
        end
        $display("test_count_sat_and_clear done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_run();
        test_saturation();
        test_overflow();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        test_count_sat_and_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
